// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the two-requester ALU sharing block.
// Holds the ALU opcode map, FSM state encoding and default bus widths.
package alu_share_arbiter_pkg;

  localparam int DATA_W = 64;
  localparam int OP_W   = 4;
  localparam int FMT_W  = 2;
  localparam int FLAG_W = 5;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_AND  = 4'b0001;
  localparam logic [3:0] ALU_OR   = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLT  = 4'b0100;
  localparam logic [3:0] ALU_SLTU = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_MOV  = 4'b1000;
  localparam logic [3:0] ALU_I2F  = 4'b1001;
  localparam logic [3:0] ALU_SUB  = 4'b1010;
  localparam logic [3:0] ALU_NOP  = 4'b1111;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

endpackage

// File: rtl/alu_share_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: a lone valid wins, a tie goes to the requester
// that did not win last. Purely combinational.
module rr_arbiter2 (
  input  logic [1:0] req_vld_i,
  input  logic       last_grant_i,
  output logic       gnt_vld_o,
  output logic       gnt_id_o
);

  always_comb begin
    gnt_vld_o = |req_vld_i;
    gnt_id_o  = 1'b0;
    if (&req_vld_i) begin
      gnt_id_o = ~last_grant_i;
    end else if (req_vld_i[1]) begin
      gnt_id_o = 1'b1;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between two requesters; result
// registered 1 cycle after accept and held until its owner takes it.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int OP_WIDTH   = OP_W,
  parameter int FMT_WIDTH  = FMT_W,
  parameter int FLAG_WIDTH = FLAG_W
) (
  input  logic                  in_clk,
  input  logic                  in_rst_n,
  input  logic                  in_flush,

  input  logic                  in_req0_valid,
  output logic                  out_req0_ready,
  input  logic [DATA_WIDTH-1:0] in_req0_rs1,
  input  logic [DATA_WIDTH-1:0] in_req0_rs2,
  input  logic [OP_WIDTH-1:0]   in_req0_op,
  input  logic [FMT_WIDTH-1:0]  in_req0_fmt,
  input  logic                  in_req0_ashift,

  input  logic                  in_req1_valid,
  output logic                  out_req1_ready,
  input  logic [DATA_WIDTH-1:0] in_req1_rs1,
  input  logic [DATA_WIDTH-1:0] in_req1_rs2,
  input  logic [OP_WIDTH-1:0]   in_req1_op,
  input  logic [FMT_WIDTH-1:0]  in_req1_fmt,
  input  logic                  in_req1_ashift,

  output logic [DATA_WIDTH-1:0] out_alu_rs1,
  output logic [DATA_WIDTH-1:0] out_alu_rs2,
  output logic [OP_WIDTH-1:0]   out_alu_op,
  output logic [FMT_WIDTH-1:0]  out_alu_fmt,
  output logic                  out_alu_ashift,
  input  logic [DATA_WIDTH-1:0] in_alu_data,
  input  logic [FLAG_WIDTH-1:0] in_alu_flag,

  output logic                  out_resp0_valid,
  input  logic                  in_resp0_ready,
  output logic                  out_resp1_valid,
  input  logic                  in_resp1_ready,
  output logic [DATA_WIDTH-1:0] out_resp_data,
  output logic [FLAG_WIDTH-1:0] out_resp_flag
);

  logic [0:0]            state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_grant_q, last_grant_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [FLAG_WIDTH-1:0] flag_q, flag_d;

  logic gnt_vld, gnt_id;
  logic resp_fire, can_accept, accept;

  rr_arbiter2 u_rr (
    .req_vld_i    ({in_req1_valid, in_req0_valid}),
    .last_grant_i (last_grant_q),
    .gnt_vld_o    (gnt_vld),
    .gnt_id_o     (gnt_id)
  );

  // Only the owner's ready frees the holding register; the other one is ignored.
  assign resp_fire  = (state_q == ST_HOLD) & (owner_q ? in_resp1_ready : in_resp0_ready);
  assign can_accept = ((state_q == ST_IDLE) | resp_fire) & ~in_flush;
  assign accept     = gnt_vld & can_accept;

  assign out_req0_ready = accept & ~gnt_id;
  assign out_req1_ready = accept &  gnt_id;

  assign out_resp0_valid = (state_q == ST_HOLD) & ~owner_q;
  assign out_resp1_valid = (state_q == ST_HOLD) &  owner_q;
  assign out_resp_data   = data_q;
  assign out_resp_flag   = flag_q;

  always_comb begin
    out_alu_rs1    = '0;
    out_alu_rs2    = '0;
    out_alu_op     = OP_WIDTH'(ALU_NOP);
    out_alu_fmt    = '0;
    out_alu_ashift = 1'b0;
    if (gnt_vld) begin
      out_alu_rs1    = gnt_id ? in_req1_rs1    : in_req0_rs1;
      out_alu_rs2    = gnt_id ? in_req1_rs2    : in_req0_rs2;
      out_alu_op     = gnt_id ? in_req1_op     : in_req0_op;
      out_alu_fmt    = gnt_id ? in_req1_fmt    : in_req0_fmt;
      out_alu_ashift = gnt_id ? in_req1_ashift : in_req0_ashift;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    data_d       = data_q;
    flag_d       = flag_q;
    if (in_flush) begin
      state_d = ST_IDLE;
      data_d  = '0;
      flag_d  = '0;
    end else if (accept) begin
      state_d      = ST_HOLD;
      owner_d      = gnt_id;
      last_grant_d = gnt_id;
      data_d       = in_alu_data;
      flag_d       = in_alu_flag;
    end else if (resp_fire) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      data_q       <= '0;
      flag_q       <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      data_q       <= data_d;
      flag_q       <= flag_d;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench: a reference ALU sits behind the arbiter; each step checks
// grants, ALU port muxing and the held response against hand-computed values.
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  logic        clk, rst_n, flush;
  logic        r0_vld, r0_rdy, r1_vld, r1_rdy;
  logic [63:0] r0_rs1, r0_rs2, r1_rs1, r1_rs2;
  logic [3:0]  r0_op, r1_op;
  logic [1:0]  r0_fmt, r1_fmt;
  logic        r0_ash, r1_ash;
  logic [63:0] alu_rs1, alu_rs2, alu_res;
  logic [3:0]  alu_op;
  logic [1:0]  alu_fmt;
  logic        alu_ash;
  logic [4:0]  alu_flag;
  logic        p0_vld, p0_rdy, p1_vld, p1_rdy;
  logic [63:0] p_dat;
  logic [4:0]  p_flag;

  int checks = 0;
  int failures = 0;

  alu_share_arbiter dut (
    .in_clk(clk), .in_rst_n(rst_n), .in_flush(flush),
    .in_req0_valid(r0_vld), .out_req0_ready(r0_rdy),
    .in_req0_rs1(r0_rs1), .in_req0_rs2(r0_rs2), .in_req0_op(r0_op),
    .in_req0_fmt(r0_fmt), .in_req0_ashift(r0_ash),
    .in_req1_valid(r1_vld), .out_req1_ready(r1_rdy),
    .in_req1_rs1(r1_rs1), .in_req1_rs2(r1_rs2), .in_req1_op(r1_op),
    .in_req1_fmt(r1_fmt), .in_req1_ashift(r1_ash),
    .out_alu_rs1(alu_rs1), .out_alu_rs2(alu_rs2), .out_alu_op(alu_op),
    .out_alu_fmt(alu_fmt), .out_alu_ashift(alu_ash),
    .in_alu_data(alu_res), .in_alu_flag(alu_flag),
    .out_resp0_valid(p0_vld), .in_resp0_ready(p0_rdy),
    .out_resp1_valid(p1_vld), .in_resp1_ready(p1_rdy),
    .out_resp_data(p_dat), .out_resp_flag(p_flag)
  );

  // Reference ALU; flags are {eq, lt signed, lt unsigned, result zero, result negative}.
  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_ADD:  alu_res = alu_rs1 + alu_rs2;
      ALU_AND:  alu_res = alu_rs1 & alu_rs2;
      ALU_OR:   alu_res = alu_rs1 | alu_rs2;
      ALU_XOR:  alu_res = alu_rs1 ^ alu_rs2;
      ALU_SLT:  alu_res = {63'b0, $signed(alu_rs1) < $signed(alu_rs2)};
      ALU_SLTU: alu_res = {63'b0, alu_rs1 < alu_rs2};
      ALU_SLL:  alu_res = alu_rs1 << alu_rs2[5:0];
      ALU_SRL:  alu_res = alu_ash ? $unsigned($signed(alu_rs1) >>> alu_rs2[5:0])
                                  : alu_rs1 >> alu_rs2[5:0];
      ALU_MOV:  alu_res = alu_rs1;
      ALU_I2F:  alu_res = (alu_fmt == 2'd0) ? alu_rs1 : {32'b0, alu_rs1[31:0]};
      ALU_SUB:  alu_res = alu_rs1 - alu_rs2;
      default:  alu_res = '0;
    endcase
    alu_flag = {alu_rs1 == alu_rs2, $signed(alu_rs1) < $signed(alu_rs2),
                alu_rs1 < alu_rs2, alu_res == 64'd0, alu_res[63]};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    r0_vld = v; r0_op = op; r0_rs1 = a; r0_rs2 = b;
  endtask

  task automatic set1(input logic v, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    r1_vld = v; r1_op = op; r1_rs1 = a; r1_rs2 = b;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #12;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    set0(1'b0, ALU_ADD, 64'd0, 64'd0); set1(1'b0, ALU_ADD, 64'd0, 64'd0);
    r0_fmt = 2'd0; r1_fmt = 2'd0; r0_ash = 1'b0; r1_ash = 1'b0;
    p0_rdy = 1'b0; p1_rdy = 1'b0;
    #1;
    chk("rst_resp0_valid", {63'b0, p0_vld}, 64'd0);
    chk("rst_resp1_valid", {63'b0, p1_vld}, 64'd0);
    chk("rst_data", p_dat, 64'd0);
    chk("rst_flag", {59'b0, p_flag}, 64'd0);
    chk("rst_alu_op_nop", {60'b0, alu_op}, 64'hF);
    do_reset();

    // Single add from req0
    set0(1'b1, ALU_ADD, 64'd5, 64'd7); p0_rdy = 1'b1;
    #1;
    chk("t1_req0_ready", {63'b0, r0_rdy}, 64'd1);
    chk("t1_req1_ready", {63'b0, r1_rdy}, 64'd0);
    chk("t1_alu_rs1", alu_rs1, 64'd5);
    tick();
    r0_vld = 1'b0;
    chk("t1_resp0_valid", {63'b0, p0_vld}, 64'd1);
    chk("t1_resp1_valid", {63'b0, p1_vld}, 64'd0);
    chk("t1_data", p_dat, 64'd12);
    chk("t1_flag", {59'b0, p_flag}, 64'h0C);
    tick();
    chk("t1_drain_valid", {63'b0, p0_vld}, 64'd0);

    // Simultaneous requests from reset alternate, starting with req0
    do_reset();
    set0(1'b1, ALU_SUB, 64'd10, 64'd3); set1(1'b1, ALU_OR, 64'hF0, 64'h0F);
    p0_rdy = 1'b1; p1_rdy = 1'b1;
    for (int k = 0; k < 18; k++) begin
      #1;
      chk("t2_req0_ready", {63'b0, r0_rdy}, (k % 2 == 0) ? 64'd1 : 64'd0);
      chk("t2_req1_ready", {63'b0, r1_rdy}, (k % 2 == 1) ? 64'd1 : 64'd0);
      tick();
      chk("t2_resp1_valid", {63'b0, p1_vld}, (k % 2 == 1) ? 64'd1 : 64'd0);
      chk("t2_data", p_dat, (k % 2 == 1) ? 64'hFF : 64'd7);
    end
    r0_vld = 1'b0; r1_vld = 1'b0;
    tick();

    // Owner stalls: result held, no overwrite, non-owner ready ignored
    set1(1'b1, ALU_XOR, 64'hAA, 64'h0F); p1_rdy = 1'b0; p0_rdy = 1'b1;
    #1;
    chk("t3_req1_ready", {63'b0, r1_rdy}, 64'd1);
    tick();
    r1_vld = 1'b0;
    set0(1'b1, ALU_ADD, 64'd20, 64'd22);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("t3_hold_valid", {63'b0, p1_vld}, 64'd1);
      chk("t3_hold_data", p_dat, 64'hA5);
      chk("t3_hold_flag", {59'b0, p_flag}, 64'd0);
      chk("t3_hold_req0_ready", {63'b0, r0_rdy}, 64'd0);
      tick();
    end
    p1_rdy = 1'b1;
    #1;
    chk("t3_release_req0_ready", {63'b0, r0_rdy}, 64'd1);
    tick();
    chk("t3_next_resp0_valid", {63'b0, p0_vld}, 64'd1);
    chk("t3_next_resp1_valid", {63'b0, p1_vld}, 64'd0);
    chk("t3_next_data", p_dat, 64'd42);
    r0_vld = 1'b0;
    tick();
    chk("t3_idle_valid", {63'b0, p0_vld}, 64'd0);

    // Streaming req0: one result per cycle
    for (int i = 1; i <= 10; i++) begin
      set0(1'b1, ALU_ADD, 64'(i), 64'(i));
      #1;
      chk("t4_stream_ready", {63'b0, r0_rdy}, 64'd1);
      tick();
      chk("t4_stream_valid", {63'b0, p0_vld}, 64'd1);
      chk("t4_stream_data", p_dat, 64'(2 * i));
    end
    // Undefined opcode passes through and yields zero
    set0(1'b1, 4'b1100, 64'd5, 64'd5);
    #1;
    chk("t4_badop_alu_op", {60'b0, alu_op}, 64'hC);
    tick();
    chk("t4_badop_data", p_dat, 64'd0);
    chk("t4_badop_flag", {59'b0, p_flag}, 64'h12);
    r0_vld = 1'b0;
    tick();

    // Flush drops the held result
    set0(1'b1, ALU_ADD, 64'd3, 64'd4); p0_rdy = 1'b0;
    tick();
    chk("t5_hold_data", p_dat, 64'd7);
    r0_vld = 1'b0;
    set1(1'b1, ALU_MOV, 64'h1234, 64'd0); p1_rdy = 1'b1; flush = 1'b1;
    #1;
    chk("t5_flush_req1_ready", {63'b0, r1_rdy}, 64'd0);
    tick();
    flush = 1'b0;
    chk("t5_flush_resp0_valid", {63'b0, p0_vld}, 64'd0);
    chk("t5_flush_resp1_valid", {63'b0, p1_vld}, 64'd0);
    #1;
    chk("t5_after_req1_ready", {63'b0, r1_rdy}, 64'd1);
    tick();
    chk("t5_after_resp1_valid", {63'b0, p1_vld}, 64'd1);
    chk("t5_after_data", p_dat, 64'h1234);
    chk("t5_after_resp0_valid", {63'b0, p0_vld}, 64'd0);
    r1_vld = 1'b0;
    tick();

    // Asynchronous reset in the middle of HOLD
    set0(1'b1, ALU_ADD, 64'd8, 64'd8); p0_rdy = 1'b0;
    tick();
    r0_vld = 1'b0;
    chk("t6_hold_valid", {63'b0, p0_vld}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", {63'b0, p0_vld}, 64'd0);
    chk("t6_async_data", p_dat, 64'd0);
    #3;
    rst_n = 1'b1;
    tick();
    set0(1'b1, ALU_ADD, 64'd1, 64'd2); set1(1'b1, ALU_MOV, 64'd5, 64'd0);
    p0_rdy = 1'b1; p1_rdy = 1'b1;
    #1;
    chk("t6_first_req0_ready", {63'b0, r0_rdy}, 64'd1);
    chk("t6_first_req1_ready", {63'b0, r1_rdy}, 64'd0);
    tick();
    chk("t6_first_data", p_dat, 64'd3);
    chk("t6_first_resp0_valid", {63'b0, p0_vld}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
